// File: rtl/bcd_7seg_scan_if.sv
// Display-side bus of bcd_7seg_scan: load/data/blank toward the driver,
// registered segment/enable/tick outputs back from it.
interface bcd_7seg_scan_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   BCD;
   logic                  blank;
   logic [6:0]            Seg;
   logic [DIGITS-1:0]     An;
   logic                  slot_tick;

   modport master (
      output load, BCD, blank,
      input  Seg, An, slot_tick
   );

   modport slave (
      input  load, BCD, blank,
      output Seg, An, slot_tick
   );
endinterface

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed multi-digit 7-segment driver.
// Captures DIGITS BCD nibbles on load, scans one digit per PRESCALE-cycle
// slot with a GUARD-cycle dark interval at the start of each slot, optional
// leading-zero blanking and a global blank input. All outputs are registered
// and reflect the scan position and data of the previous cycle.
// Macro BCD_7SEG_HEX_EN: when defined, codes 10-15 show hex glyphs A b C d E F;
// otherwise they show a dash.
module bcd_7seg_scan #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned PRESCALE = 1000,
   parameter int unsigned GUARD    = 1,
   parameter int unsigned LZ_BLANK = 1
) (
   input  logic               clk,
   input  logic               rst,
   bcd_7seg_scan_if.slave     bus
);

   localparam int unsigned CNT_W = $clog2(PRESCALE);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*DIGITS-1:0]   data_q, data_d;
   logic [6:0]            seg_q, seg_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  tick_q, tick_d;

   logic [DIGITS-1:0]     lz_mask;
   logic [3:0]            nib;
   logic                  nib_blanked;
   logic                  slot_active;

   // Segment pattern {g,f,e,d,c,b,a} for one BCD code.
   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
`ifdef BCD_7SEG_HEX_EN
         4'd10:   s = 7'b1110111;
         4'd11:   s = 7'b1111100;
         4'd12:   s = 7'b0111001;
         4'd13:   s = 7'b1011110;
         4'd14:   s = 7'b1111001;
         default: s = 7'b1110001;
`else
         default: s = 7'b1000000;
`endif
      endcase
      return s;
   endfunction

   // Prescaler and digit index: cnt wraps each slot, idx advances on wrap.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Display register capture; independent of the scan position.
   always_comb begin
      data_d = data_q;
      if (bus.load) begin
         data_d = bus.BCD;
      end
   end

   // Leading-zero mask: walk from the top digit down, blanking while every
   // nibble seen so far is zero. Digit 0 is never blanked.
   always_comb begin
      logic any_nz;
      any_nz  = 1'b0;
      lz_mask = '0;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         if (data_q[4*(DIGITS-1-j) +: 4] != 4'd0) begin
            any_nz = 1'b1;
         end
         lz_mask[DIGITS-1-j] = (LZ_BLANK != 0) && ((DIGITS-1-j) != 0) && !any_nz;
      end
   end

   // Select the active digit's nibble and blanking flag.
   always_comb begin
      nib         = '0;
      nib_blanked = 1'b0;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         if (idx_q == IDX_W'(j)) begin
            nib         = data_q[4*j +: 4];
            nib_blanked = lz_mask[j];
         end
      end
   end

   // Next output values from this cycle's scan position and data.
   always_comb begin
      slot_active = (cnt_q >= CNT_GUARD) && !bus.blank;
      an_d        = '0;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         an_d[j] = slot_active && (idx_q == IDX_W'(j));
      end
      seg_d  = (slot_active && !nib_blanked) ? decode(nib) : '0;
      tick_d = (cnt_q == CNT_LAST);
   end

   // Scan position register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   // Display data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q  <= '0;
         an_q   <= '0;
         tick_q <= 1'b0;
      end else begin
         seg_q  <= seg_d;
         an_q   <= an_d;
         tick_q <= tick_d;
      end
   end

   assign bus.Seg       = seg_q;
   assign bus.An        = an_q;
   assign bus.slot_tick = tick_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan with DIGITS=4, PRESCALE=4, GUARD=1,
// LZ_BLANK=1. The scan position (0..15 = idx*4+cnt) is tracked locally and
// expected glyphs per digit are hand-written per scenario.
module tb_bcd_7seg_scan;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bcd_7seg_scan_if #(.DIGITS(4)) bus ();

   bcd_7seg_scan #(
      .DIGITS(4),
      .PRESCALE(4),
      .GUARD(1),
      .LZ_BLANK(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int st     = 0;

   logic [6:0] exp_dig [4];
   logic [3:0] ex_an;
   logic [6:0] ex_seg;
   logic       ex_tick;

   // One clock; computes the outputs expected after this edge.
   task automatic step();
      logic r, b;
      int   s;
      r = rst;
      b = bus.blank;
      s = st;
      @(posedge clk);
      #1;
      if (r) begin
         ex_an   = 4'b0000;
         ex_seg  = 7'b0000000;
         ex_tick = 1'b0;
         st      = 0;
      end else begin
         ex_tick = ((s % 4) == 3);
         ex_an   = ((s % 4) >= 1 && !b) ? (4'b0001 << (s / 4)) : 4'b0000;
         ex_seg  = (ex_an != 4'b0000) ? exp_dig[s / 4] : 7'b0000000;
         st      = (s + 1) % 16;
      end
   endtask

   task automatic advance_to(input int target);
      for (int n = 0; n < 32 && st != target; n++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++; if (bus.An !== 4'b0000) begin errors++; $display("FAIL reset_an got %b exp 0000", bus.An); end
         checks++; if (bus.Seg !== 7'b0000000) begin errors++; $display("FAIL reset_seg got %b exp 0000000", bus.Seg); end
         checks++; if (bus.slot_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", bus.slot_tick); end
      end
      rst = 1'b0;
      exp_dig = '{7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000};
   endtask

   task automatic test_scan();
      int ticks;
      ticks = 0;
      for (int c = 0; c < 33; c++) begin
         bus.load = (c == 0);
         bus.BCD  = 16'h1234;
         step();
         checks++; if (bus.An !== ex_an) begin errors++; $display("FAIL scan_an c=%0d got %b exp %b", c, bus.An, ex_an); end
         checks++; if (bus.Seg !== ex_seg) begin errors++; $display("FAIL scan_seg c=%0d got %b exp %b", c, bus.Seg, ex_seg); end
         checks++; if (bus.slot_tick !== ex_tick) begin errors++; $display("FAIL scan_tick c=%0d got %b exp %b", c, bus.slot_tick, ex_tick); end
         if (bus.slot_tick === 1'b1) ticks++;
         if (c == 0) exp_dig = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
      end
      bus.load = 1'b0;
      checks++; if (ticks != 8) begin errors++; $display("FAIL scan_tick_count got %0d exp 8", ticks); end
   endtask

   task automatic test_leading_zero();
      for (int c = 0; c < 17; c++) begin
         bus.load = (c == 0);
         bus.BCD  = 16'h0070;
         step();
         checks++; if (bus.An !== ex_an) begin errors++; $display("FAIL lz70_an c=%0d got %b exp %b", c, bus.An, ex_an); end
         checks++; if (bus.Seg !== ex_seg) begin errors++; $display("FAIL lz70_seg c=%0d got %b exp %b", c, bus.Seg, ex_seg); end
         if (c == 0) exp_dig = '{7'b0111111, 7'b0000111, 7'b0000000, 7'b0000000};
      end
      for (int c = 0; c < 17; c++) begin
         bus.load = (c == 0);
         bus.BCD  = 16'h0000;
         step();
         checks++; if (bus.An !== ex_an) begin errors++; $display("FAIL lz00_an c=%0d got %b exp %b", c, bus.An, ex_an); end
         checks++; if (bus.Seg !== ex_seg) begin errors++; $display("FAIL lz00_seg c=%0d got %b exp %b", c, bus.Seg, ex_seg); end
         if (c == 0) exp_dig = '{7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000};
      end
      bus.load = 1'b0;
   endtask

   task automatic test_invalid();
      for (int c = 0; c < 17; c++) begin
         bus.load = (c == 0);
         bus.BCD  = 16'h00A5;
         step();
         checks++; if (bus.An !== ex_an) begin errors++; $display("FAIL inv_an c=%0d got %b exp %b", c, bus.An, ex_an); end
         checks++; if (bus.Seg !== ex_seg) begin errors++; $display("FAIL inv_seg c=%0d got %b exp %b", c, bus.Seg, ex_seg); end
`ifdef BCD_7SEG_HEX_EN
         if (c == 0) exp_dig = '{7'b1101101, 7'b1110111, 7'b0000000, 7'b0000000};
`else
         if (c == 0) exp_dig = '{7'b1101101, 7'b1000000, 7'b0000000, 7'b0000000};
`endif
      end
      bus.load = 1'b0;
   endtask

   task automatic test_reset_mid();
      advance_to(10);
      rst = 1'b1;
      step();
      checks++; if (bus.An !== 4'b0000) begin errors++; $display("FAIL rstmid_an got %b exp 0000", bus.An); end
      checks++; if (bus.Seg !== 7'b0000000) begin errors++; $display("FAIL rstmid_seg got %b exp 0000000", bus.Seg); end
      checks++; if (bus.slot_tick !== 1'b0) begin errors++; $display("FAIL rstmid_tick got %b exp 0", bus.slot_tick); end
      rst = 1'b0;
      exp_dig = '{7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000};
      for (int c = 0; c < 10; c++) begin
         step();
         checks++; if (bus.An !== ex_an) begin errors++; $display("FAIL rstmid_scan_an c=%0d got %b exp %b", c, bus.An, ex_an); end
         checks++; if (bus.Seg !== ex_seg) begin errors++; $display("FAIL rstmid_scan_seg c=%0d got %b exp %b", c, bus.Seg, ex_seg); end
         checks++; if (bus.slot_tick !== ex_tick) begin errors++; $display("FAIL rstmid_scan_tick c=%0d got %b exp %b", c, bus.slot_tick, ex_tick); end
      end
   endtask

   task automatic test_blank();
      bus.blank = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus.load = (c == 3);
         bus.BCD  = 16'h9999;
         step();
         checks++; if (bus.An !== ex_an) begin errors++; $display("FAIL blank_an c=%0d got %b exp %b", c, bus.An, ex_an); end
         checks++; if (bus.Seg !== ex_seg) begin errors++; $display("FAIL blank_seg c=%0d got %b exp %b", c, bus.Seg, ex_seg); end
         checks++; if (bus.slot_tick !== ex_tick) begin errors++; $display("FAIL blank_tick c=%0d got %b exp %b", c, bus.slot_tick, ex_tick); end
         if (c == 3) exp_dig = '{7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
      end
      bus.load  = 1'b0;
      bus.blank = 1'b0;
      for (int c = 0; c < 16; c++) begin
         step();
         checks++; if (bus.An !== ex_an) begin errors++; $display("FAIL unblank_an c=%0d got %b exp %b", c, bus.An, ex_an); end
         checks++; if (bus.Seg !== ex_seg) begin errors++; $display("FAIL unblank_seg c=%0d got %b exp %b", c, bus.Seg, ex_seg); end
      end
   endtask

   task automatic test_load_timing();
      advance_to(1);
      for (int c = 0; c < 9; c++) begin
         bus.load = (c == 0);
         bus.BCD  = 16'h5555;
         step();
         checks++; if (bus.An !== ex_an) begin errors++; $display("FAIL ldt_an c=%0d got %b exp %b", c, bus.An, ex_an); end
         checks++; if (bus.Seg !== ex_seg) begin errors++; $display("FAIL ldt_seg c=%0d got %b exp %b", c, bus.Seg, ex_seg); end
         checks++; if (bus.slot_tick !== ex_tick) begin errors++; $display("FAIL ldt_tick c=%0d got %b exp %b", c, bus.slot_tick, ex_tick); end
         if (c == 0) exp_dig = '{7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101};
      end
      bus.load = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      bus.load  = 1'b0;
      bus.BCD   = '0;
      bus.blank = 1'b0;
      exp_dig   = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
      test_reset();
      test_scan();
      test_leading_zero();
      test_invalid();
      test_reset_mid();
      test_blank();
      test_load_timing();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_7seg_scan.md
Name: bcd_7seg_scan

Overview:
- Multi-digit, time-multiplexed 7-segment display driver. It is the parametrised successor to bcd_to_7seg.
- Captures a packed vector of DIGITS BCD nibbles on a load strobe, then scans one digit at a time onto a shared segment bus with one-hot digit enables.
- Adds a refresh prescaler, an anti-ghosting guard interval, leading-zero blanking and a global blank input.
- Sits between the counter/datapath logic and the board display pins.

Parameters:
- DIGITS, 4: number of digits scanned; 1 to 8.
- PRESCALE, 1000: clock cycles per digit slot; at least 2.
- GUARD, 1: cycles at the start of each slot with all enables off; 0 to PRESCALE-1.
- LZ_BLANK, 1: 1 = suppress leading zeros; 0 = show all digits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load  in  1  capture BCD into the display register on this edge
- BCD  in  4*DIGITS  packed nibbles; nibble i = BCD[4i+3:4i], digit 0 is least significant
- blank  in  1  force display dark; scanning continues
- Seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered
- An  out  DIGITS  one-hot digit enable, active-high, registered
- slot_tick  out  1  one-cycle pulse on the last cycle of each slot, registered

Behaviour:
- Reset (rst=1 at an edge):
  - cnt=0, idx=0, data_q=0.
  - Seg=0, An=0, slot_tick=0 on the following cycle.
  - Reset mid-scan abandons the current slot; the scan restarts at digit 0.
- Prescaler:
  - cnt counts 0..PRESCALE-1.
  - When cnt==PRESCALE-1, cnt wraps to 0 and idx advances.
  - idx wraps DIGITS-1 -> 0.
- Capture:
  - load=1 at an edge writes data_q <= BCD; rst has priority.
  - load held high recaptures on every edge.
  - A capture does not disturb cnt or idx.
- Output pipeline: outputs at cycle t+1 are a function of cnt, idx and data_q at cycle t.
  - Load at edge k therefore reaches Seg after edge k+1, provided that digit is active.
- An:
  - onehot(idx) when cnt >= GUARD and blank=0.
  - Otherwise all zero.
- Seg:
  - decode(data_q nibble idx) when An is non-zero and the digit is not blanked.
  - Otherwise 0.
- Decode table:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Codes 10-15: see Optional Feature.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit i is blanked (Seg=0, An still asserted) when every nibble from i up to DIGITS-1 equals 0.
  - Digit 0 is never blanked.
  - Invalid codes 10-15 count as non-zero.
- slot_tick is 1 on the output cycle corresponding to cnt==PRESCALE-1. It is independent of blank.
- Simultaneous events:
  - load and a slot change on the same edge: both take effect; the new digit shows the new data.
  - blank and load together: data is still captured.

Optional Feature:
- Macro: BCD_7SEG_HEX_EN.
- Defined: codes 10-15 display hex glyphs.
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Undefined: codes 10-15 display a dash, 1000000.

Test Plan:
- Parameters for all scenarios: DIGITS=4, PRESCALE=4, GUARD=1, LZ_BLANK=1.
- Scan order: reset, then load BCD=16'h1234. Response:
  - Each slot shows An=0000 for 1 cycle, then 3 cycles active.
  - Active values in order: An=0001/Seg=1100110, An=0010/Seg=1001111, An=0100/Seg=1011011, An=1000/Seg=0000110.
  - slot_tick pulses every 4 cycles; the pattern repeats after 16 cycles.
- Leading zeros: load 16'h0070. Response:
  - Digits 3 and 2: Seg=0000000 while An is active.
  - Digit 1: Seg=0000111. Digit 0: Seg=0111111.
  - Then load 16'h0000: only digit 0 shows 0111111.
- Invalid code: load 16'h00A5. Response:
  - Digit 0: Seg=1101101.
  - Digit 1: Seg=1000000 without the macro, 1110111 with it.
  - Digits 3 and 2 are blanked.
- Reset mid-scan: assert rst while idx=2, cnt=2. Response:
  - Next cycle: Seg=0, An=0, slot_tick=0.
  - After release, the first active enable is An=0001, with data_q=0 so Seg=0111111.
- Blank: hold blank=1 for 10 cycles and pulse load with 16'h9999 during it. Response:
  - An=0000 and Seg=0 throughout; slot_tick keeps pulsing.
  - After blank drops, every digit shows 1101111.
- Load timing: load 16'h5555 mid-slot at edge k while digit 0 is active. Response:
  - Seg is unchanged after edge k.
  - Seg=1101101 after edge k+1.
  - The slot boundary is unmoved.
